// File: rtl/sel_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : sel_decode_queue
// Purpose  : Small FIFO of {en, sel} requests. The head entry is presented
//            as a one-hot decode (out_onehot) together with its raw index.
//            Optional macro SEL_ZERO_SUPPRESS_EN: when defined, a head entry
//            with sel == 0 decodes to all-zero (hardwired register 0).
// Revision : 1.0 - initial release
// ============================================================================
module sel_decode_queue #(
    parameter int SEL_W = 5,
    parameter int DEPTH = 4,
    localparam int OUT_W = 2**SEL_W,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [SEL_W-1:0] in_sel,
    input  logic             in_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_onehot,
    output logic [SEL_W-1:0] out_index,
    output logic [CNT_W-1:0] count
);

    // DEPTH is a power of two, so the pointers wrap naturally at PTR_W bits.
    localparam int PTR_W   = $clog2(DEPTH);
    localparam int ENTRY_W = SEL_W + 1;

    logic [ENTRY_W-1:0] mem_q [DEPTH];
    logic [ENTRY_W-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]   count_q,  count_d;

    logic               w_push;
    logic               w_pop;
    logic [ENTRY_W-1:0] w_head;
    logic [SEL_W-1:0]   w_head_sel;
    logic               w_head_en;
    logic               w_head_live;

    // Handshake qualifiers: full ignores pushes, empty ignores pops.
    always_comb begin
        in_ready  = (count_q != CNT_W'(DEPTH));
        out_valid = (count_q != '0);
        w_push    = in_valid && in_ready;
        w_pop     = out_valid && out_ready;
    end

    // Next-state for pointers, occupancy and storage; storage only changes on a push.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        mem_d    = mem_q;
        if (w_push) begin
            mem_d[wr_ptr_q] = {in_en, in_sel};
            wr_ptr_d        = wr_ptr_q + PTR_W'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
        end
        if (w_push && !w_pop) begin
            count_d = count_q + CNT_W'(1);
        end else if (!w_push && w_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Control state: asynchronously cleared, which discards every queued entry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage is never reset; stale contents are unreachable once count is 0.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    // Head decode: zero outputs whenever the queue is empty.
    always_comb begin
        w_head     = mem_q[rd_ptr_q];
        w_head_sel = w_head[SEL_W-1:0];
        w_head_en  = w_head[ENTRY_W-1];
`ifdef SEL_ZERO_SUPPRESS_EN
        w_head_live = w_head_en && (w_head_sel != '0);
`else
        w_head_live = w_head_en;
`endif
        out_index  = out_valid ? w_head_sel : '0;
        out_onehot = (out_valid && w_head_live) ? (OUT_W'(1) << w_head_sel) : '0;
        count      = count_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_sel_decode_queue.sv
`default_nettype none
// ============================================================================
// Module   : tb_sel_decode_queue
// Purpose  : Self-checking bench for sel_decode_queue (SEL_W=5, DEPTH=4).
//            A queue-based reference model is compared every cycle, and
//            directed scenarios pin hand-computed literal values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sel_decode_queue;

    localparam int SEL_W = 5;
    localparam int DEPTH = 4;
    localparam int OUT_W = 32;
    localparam int CNT_W = 3;
`ifdef SEL_ZERO_SUPPRESS_EN
    localparam bit SUP = 1'b1;
`else
    localparam bit SUP = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [SEL_W-1:0] in_sel = '0;
    logic             in_en = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [OUT_W-1:0] out_onehot;
    logic [SEL_W-1:0] out_index;
    logic [CNT_W-1:0] count;

    int total = 0;
    int bad   = 0;

    // Reference model: each entry is {en, sel}.
    logic [SEL_W:0] model_q[$];

    sel_decode_queue #(.SEL_W(SEL_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_sel    (in_sel),
        .in_en     (in_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_onehot(out_onehot),
        .out_index (out_index),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected decode of an entry, from the rule "1 << sel if enabled".
    function automatic logic [OUT_W-1:0] decode(input logic [SEL_W:0] e);
        logic [SEL_W-1:0] s;
        logic [63:0]      p;
        s = e[SEL_W-1:0];
        p = 64'd1;
        for (int k = 0; k < int'(s); k++) p = p * 2;
        if (!e[SEL_W] || (SUP && s == '0)) return '0;
        return p[OUT_W-1:0];
    endfunction

    // Model update on every rising edge, using the model's own occupancy.
    always @(posedge clk) begin
        if (rst_n) begin
            logic do_push, do_pop;
            do_push = in_valid && (model_q.size() != DEPTH);
            do_pop  = out_ready && (model_q.size() != 0);
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back({in_en, in_sel});
        end
    end

    always @(negedge rst_n) model_q.delete();

    // Compare every cycle on the falling edge.
    always @(negedge clk) begin
        logic [SEL_W:0] h;
        h = (model_q.size() != 0) ? model_q[0] : '0;
        chk("m_count", 64'(count), 64'(model_q.size()));
        chk("m_in_ready", 64'(in_ready), 64'(model_q.size() != DEPTH));
        chk("m_out_valid", 64'(out_valid), 64'(model_q.size() != 0));
        chk("m_out_index", 64'(out_index), 64'((model_q.size() != 0) ? h[SEL_W-1:0] : '0));
        chk("m_out_onehot", 64'(out_onehot), 64'((model_q.size() != 0) ? decode(h) : '0));
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push_cfg(input bit v, input int s, input bit e, input bit r);
        in_valid  = v;
        in_sel    = SEL_W'(s);
        in_en     = e;
        out_ready = r;
    endtask

    initial begin
        // Reset state
        repeat (3) step();
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_onehot", 64'(out_onehot), 64'd0);
        chk("rst_index", 64'(out_index), 64'd0);

        // Push 17 immediately after reset release, consumer always ready
        rst_n = 1'b1;
        push_cfg(1, 17, 1, 1);
        step();
        chk("p17_valid", 64'(out_valid), 64'd1);
        chk("p17_onehot", 64'(out_onehot), 64'h0002_0000);
        chk("p17_index", 64'(out_index), 64'd17);
        push_cfg(0, 0, 0, 1);
        step();
        chk("p17_drained", 64'(out_valid), 64'd0);

        // Fill to full, overflow push ignored, then drain in order
        push_cfg(1, 3, 1, 0);  step();
        push_cfg(1, 7, 1, 0);  step();
        push_cfg(1, 31, 1, 0); step();
        push_cfg(1, 9, 1, 0);  step();
        chk("full_count", 64'(count), 64'd4);
        chk("full_ready", 64'(in_ready), 64'd0);
        push_cfg(1, 5, 1, 0);  step();
        chk("ovf_count", 64'(count), 64'd4);
        chk("ovf_head", 64'(out_onehot), 64'h8);
        push_cfg(0, 0, 0, 1);
        chk("drain0", 64'(out_onehot), 64'h8);
        step(); chk("drain1", 64'(out_onehot), 64'h80);
        step(); chk("drain2", 64'(out_onehot), 64'h8000_0000);
        step(); chk("drain3", 64'(out_onehot), 64'h200);
        step(); chk("drain_empty", 64'(out_valid), 64'd0);
        step(); chk("empty_pop_count", 64'(count), 64'd0);

        // Disabled entry
        push_cfg(1, 12, 0, 0); step();
        chk("en0_valid", 64'(out_valid), 64'd1);
        chk("en0_onehot", 64'(out_onehot), 64'd0);
        chk("en0_index", 64'(out_index), 64'd12);
        push_cfg(0, 0, 0, 1); step();

        // Select zero, enabled
        push_cfg(1, 0, 1, 0); step();
        chk("sel0_valid", 64'(out_valid), 64'd1);
        chk("sel0_onehot", 64'(out_onehot), SUP ? 64'h0 : 64'h1);
        push_cfg(0, 0, 0, 1); step();

        // Simultaneous push/pop at count 2 across pointer wrap
        push_cfg(1, 20, 1, 0); step();
        push_cfg(1, 21, 1, 0); step();
        for (int k = 1; k <= 6; k++) begin
            push_cfg(1, 21 + k, 1, 1);
            step();
            chk("pp_count", 64'(count), 64'd2);
            chk("pp_index", 64'(out_index), 64'(20 + k));
        end
        push_cfg(0, 0, 0, 1); step(); step();
        chk("pp_drained", 64'(count), 64'd0);

        // Mixed traffic checked by the model
        for (int i = 0; i < 24; i++) begin
            push_cfg((i % 3) != 0, (i * 7) % 32, (i % 5) != 0, (i % 2) == 1);
            step();
        end

        // Reset mid-stream with three entries queued
        push_cfg(0, 0, 0, 1); repeat (4) step();
        push_cfg(1, 1, 1, 0); step();
        push_cfg(1, 2, 1, 0); step();
        push_cfg(1, 4, 1, 0); step();
        push_cfg(0, 0, 0, 0);
        chk("pre_rst_count", 64'(count), 64'd3);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_count", 64'(count), 64'd0);
        chk("arst_valid", 64'(out_valid), 64'd0);
        chk("arst_onehot", 64'(out_onehot), 64'd0);
        chk("arst_ready", 64'(in_ready), 64'd1);
        step();
        rst_n = 1'b1;
        push_cfg(1, 2, 1, 0); step();
        chk("post_rst_onehot", 64'(out_onehot), 64'h4);
        chk("post_rst_count", 64'(count), 64'd1);
        push_cfg(0, 0, 0, 1); step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
